// File: rtl/led_sequencer_if.sv
// rtl/led_sequencer_if.sv - control and LED pattern bundle between tick source and led_sequencer
interface led_sequencer_if #(
  parameter int NB_LEDS = 8,
  parameter int NB_DIV  = 8
);

  logic               i_valid;
  logic [NB_DIV-1:0]  i_div;
  logic [1:0]         i_mode;
  logic               i_load;
  logic [NB_LEDS-1:0] i_pattern;
  logic [NB_LEDS-1:0] o_led;
  logic               o_dir;
  logic               o_wrap;

  modport master (
    output i_valid,
    output i_div,
    output i_mode,
    output i_load,
    output i_pattern,
    input  o_led,
    input  o_dir,
    input  o_wrap
  );

  modport slave (
    input  i_valid,
    input  i_div,
    input  i_mode,
    input  i_load,
    input  i_pattern,
    output o_led,
    output o_dir,
    output o_wrap
  );

endinterface

// File: rtl/led_sequencer.sv
// rtl/led_sequencer.sv - prescaled LED pattern sequencer (rotate left/right, bounce, fill)
module led_sequencer #(
  parameter int NB_LEDS = 8,
  parameter int NB_DIV  = 8
) (
  input  logic          clk,
  input  logic          i_rst_n,
  led_sequencer_if.slave bus
);

  localparam logic [1:0] MODE_ROL    = 2'b00;
  localparam logic [1:0] MODE_ROR    = 2'b01;
  localparam logic [1:0] MODE_BOUNCE = 2'b10;
  localparam logic [1:0] MODE_FILL   = 2'b11;

  localparam logic [NB_LEDS-1:0] LED_RESET = NB_LEDS'(1);
  localparam logic [NB_LEDS-1:0] LED_ONES  = {NB_LEDS{1'b1}};
  localparam logic [NB_DIV-1:0]  CNT_ONE   = NB_DIV'(1);

  logic [NB_LEDS-1:0] led_q, led_d;
  logic               dir_q, dir_d;
  logic               wrap_q, wrap_d;
  logic [NB_DIV-1:0]  cnt_q, cnt_d;

  logic [NB_LEDS-1:0] step_led;
  logic               step_dir;
  logic               step_wrap;
  logic               step_hit;

  // The count is compared for equality only, so a divide value lowered
  // below the running count lets the counter wrap before it matches.
  assign step_hit = bus.i_valid && (cnt_q == bus.i_div);

  always_comb begin
    step_led  = led_q;
    step_dir  = dir_q;
    step_wrap = 1'b0;
    case (bus.i_mode)
      MODE_ROL: begin
        step_led  = {led_q[NB_LEDS-2:0], led_q[NB_LEDS-1]};
        step_dir  = 1'b1;
        step_wrap = led_q[NB_LEDS-1];
      end
      MODE_ROR: begin
        step_led  = {led_q[0], led_q[NB_LEDS-1:1]};
        step_dir  = 1'b0;
        step_wrap = led_q[0];
      end
      MODE_BOUNCE: begin
        // Zero-fill shifts: an empty pattern stays empty and never reverses.
        if (dir_q) begin
          if (led_q[NB_LEDS-1]) begin
            step_led  = led_q >> 1;
            step_dir  = 1'b0;
            step_wrap = 1'b1;
          end else begin
            step_led  = led_q << 1;
          end
        end else begin
          if (led_q[0]) begin
            step_led  = led_q << 1;
            step_dir  = 1'b1;
            step_wrap = 1'b1;
          end else begin
            step_led  = led_q >> 1;
          end
        end
      end
      MODE_FILL: begin
        step_dir = 1'b1;
        if (led_q == LED_ONES) begin
          step_led  = LED_RESET;
          step_wrap = 1'b1;
        end else begin
          step_led  = {led_q[NB_LEDS-2:0], 1'b1};
        end
      end
      default: begin
        step_led  = led_q;
        step_dir  = dir_q;
        step_wrap = 1'b0;
      end
    endcase
  end

  always_comb begin
    led_d  = led_q;
    dir_d  = dir_q;
    cnt_d  = cnt_q;
    wrap_d = 1'b0;
    if (bus.i_load) begin
      led_d = bus.i_pattern;
      dir_d = 1'b1;
      cnt_d = '0;
    end else if (step_hit) begin
      led_d  = step_led;
      dir_d  = step_dir;
      wrap_d = step_wrap;
      cnt_d  = '0;
    end else if (bus.i_valid) begin
      cnt_d = cnt_q + CNT_ONE;
    end
  end

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      led_q  <= LED_RESET;
      dir_q  <= 1'b1;
      wrap_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      led_q  <= led_d;
      dir_q  <= dir_d;
      wrap_q <= wrap_d;
      cnt_q  <= cnt_d;
    end
  end

  assign bus.o_led  = led_q;
  assign bus.o_dir  = dir_q;
  assign bus.o_wrap = wrap_q;

endmodule

// File: tb/tb_led_sequencer.sv
// tb/tb_led_sequencer.sv - scoreboard bench for led_sequencer with 4 LEDs
module tb_led_sequencer;

  localparam int NB_LEDS = 4;
  localparam int NB_DIV  = 8;

  typedef struct {
    logic [NB_LEDS-1:0] led;
    logic               dir;
    logic               wrap;
    string              tag;
  } exp_t;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_err;
  exp_t sb_q[$];

  led_sequencer_if #(.NB_LEDS(NB_LEDS), .NB_DIV(NB_DIV)) bus ();

  led_sequencer #(.NB_LEDS(NB_LEDS), .NB_DIV(NB_DIV)) dut (
    .clk     (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [NB_LEDS+1:0] act, input logic [NB_LEDS+1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got led/dir/wrap=%b/%b/%b, expected %b/%b/%b", name,
               act[NB_LEDS+1:2], act[1], act[0], exp[NB_LEDS+1:2], exp[1], exp[0]);
    end
  endtask

  task automatic drive(input logic v, input logic ld, input logic [NB_LEDS-1:0] pat,
                       input logic [1:0] md, input logic [NB_DIV-1:0] dv,
                       input logic [NB_LEDS-1:0] e_led, input logic e_dir, input logic e_wrap,
                       input string tag);
    exp_t e;
    @(negedge clk);
    bus.i_valid   = v;
    bus.i_load    = ld;
    bus.i_pattern = pat;
    bus.i_mode    = md;
    bus.i_div     = dv;
    e.led  = e_led;
    e.dir  = e_dir;
    e.wrap = e_wrap;
    e.tag  = tag;
    sb_q.push_back(e);
  endtask

  // Monitor: the registered outputs after every edge are compared against the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        check(e.tag, {bus.o_led, bus.o_dir, bus.o_wrap}, {e.led, e.dir, e.wrap});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst_n = 1'b0;
    bus.i_valid   = 1'b0;
    bus.i_load    = 1'b0;
    bus.i_pattern = '0;
    bus.i_mode    = 2'b00;
    bus.i_div     = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_state", {bus.o_led, bus.o_dir, bus.o_wrap}, {4'b0001, 1'b1, 1'b0});
    @(negedge clk);
    rst_n = 1'b1;

    // Rotate left, one step per valid tick
    drive(1, 0, 4'h0, 2'b00, 8'd0, 4'b0010, 1, 0, "rol_1");
    drive(1, 0, 4'h0, 2'b00, 8'd0, 4'b0100, 1, 0, "rol_2");
    drive(1, 0, 4'h0, 2'b00, 8'd0, 4'b1000, 1, 0, "rol_3");
    drive(1, 0, 4'h0, 2'b00, 8'd0, 4'b0001, 1, 1, "rol_wrap");

    // Prescaler: div=2, valid every other cycle
    for (int k = 0; k < 6; k++)
      drive((k % 2) == 0, 0, 4'h0, 2'b00, 8'd2, (k < 4) ? 4'b0001 : 4'b0010, 1, 0, "presc_a");
    for (int k = 0; k < 6; k++)
      drive((k % 2) == 0, 0, 4'h0, 2'b00, 8'd2, (k < 4) ? 4'b0010 : 4'b0100, 1, 0, "presc_b");

    // Rotate right, then bounce
    drive(0, 1, 4'b0001, 2'b00, 8'd0, 4'b0001, 1, 0, "load_ror");
    drive(1, 0, 4'h0, 2'b01, 8'd0, 4'b1000, 0, 1, "ror_wrap");
    drive(1, 0, 4'h0, 2'b01, 8'd0, 4'b0100, 0, 0, "ror_2");
    drive(1, 0, 4'h0, 2'b01, 8'd0, 4'b0010, 0, 0, "ror_3");
    drive(1, 0, 4'h0, 2'b10, 8'd0, 4'b0001, 0, 0, "bnc_down");
    drive(1, 0, 4'h0, 2'b10, 8'd0, 4'b0010, 1, 1, "bnc_rev_lo");
    drive(1, 0, 4'h0, 2'b10, 8'd0, 4'b0100, 1, 0, "bnc_up1");
    drive(1, 0, 4'h0, 2'b10, 8'd0, 4'b1000, 1, 0, "bnc_up2");
    drive(1, 0, 4'h0, 2'b10, 8'd0, 4'b0100, 0, 1, "bnc_rev_hi");

    // Fill
    drive(0, 1, 4'b0001, 2'b11, 8'd0, 4'b0001, 1, 0, "load_fill");
    drive(1, 0, 4'h0, 2'b11, 8'd0, 4'b0011, 1, 0, "fill_1");
    drive(1, 0, 4'h0, 2'b11, 8'd0, 4'b0111, 1, 0, "fill_2");
    drive(1, 0, 4'h0, 2'b11, 8'd0, 4'b1111, 1, 0, "fill_3");
    drive(1, 0, 4'h0, 2'b11, 8'd0, 4'b0001, 1, 1, "fill_wrap");

    // Load mid-count restarts the prescaler
    drive(1, 0, 4'h0, 2'b00, 8'd3, 4'b0001, 1, 0, "cnt_to_1");
    drive(1, 1, 4'b0101, 2'b00, 8'd3, 4'b0101, 1, 0, "load_mid");
    for (int k = 0; k < 3; k++)
      drive(1, 0, 4'h0, 2'b00, 8'd3, 4'b0101, 1, 0, "post_load_hold");
    drive(1, 0, 4'h0, 2'b00, 8'd3, 4'b1010, 1, 0, "post_load_step");

    // All-zero pattern stays zero without wrap
    drive(1, 1, 4'b0000, 2'b00, 8'd0, 4'b0000, 1, 0, "load_zero");
    for (int k = 0; k < 3; k++)
      drive(1, 0, 4'h0, 2'b00, 8'd0, 4'b0000, 1, 0, "zero_rol");
    for (int k = 0; k < 2; k++)
      drive(1, 0, 4'h0, 2'b10, 8'd0, 4'b0000, 1, 0, "zero_bnc");

    // Build led=1000, count=2, dir=0, then reset asynchronously
    drive(0, 1, 4'b0001, 2'b01, 8'd3, 4'b0001, 1, 0, "load_pre_rst");
    drive(1, 0, 4'h0, 2'b01, 8'd0, 4'b1000, 0, 1, "pre_rst_step");
    drive(1, 0, 4'h0, 2'b01, 8'd3, 4'b1000, 0, 0, "pre_rst_cnt1");
    drive(1, 0, 4'h0, 2'b01, 8'd3, 4'b1000, 0, 0, "pre_rst_cnt2");
    @(negedge clk);
    bus.i_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset", {bus.o_led, bus.o_dir, bus.o_wrap}, {4'b0001, 1'b1, 1'b0});
    @(posedge clk);
    #1;
    check("reset_held", {bus.o_led, bus.o_dir, bus.o_wrap}, {4'b0001, 1'b1, 1'b0});
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++)
      drive(1, 0, 4'h0, 2'b00, 8'd3, 4'b0001, 1, 0, "post_rst_hold");
    drive(1, 0, 4'h0, 2'b00, 8'd3, 4'b0010, 1, 0, "post_rst_step");

    begin
      int budget;
      budget = 20;
      while (sb_q.size() > 0 && budget > 0) begin
        @(posedge clk);
        budget--;
      end
      #2;
      n_cmp++;
      if (sb_q.size() != 0) begin
        n_err++;
        $display("FAIL drain: got %0d pending, expected 0", sb_q.size());
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/led_sequencer.md
# led_sequencer

Parametrised LED pattern sequencer that generalises the single-bit rotating LED register. It supports any LED count, a programmable step prescaler, four motion modes (rotate left, rotate right, bounce, fill), synchronous pattern load, and a wrap/reversal event pulse. It sits between the tick/enable source and the board LED pins of the counter_leds design.

## Interface
- NB_LEDS, 8: number of LEDs; legal range ≥ 2.
- NB_DIV, 8: width of the prescaler divide value.

- clk  input  1  system clock; all state updates on the rising edge.
- i_rst_n  input  1  asynchronous, active-low reset.
- i_valid  input  1  tick qualifier; only cycles with i_valid=1 advance the prescaler.
- i_div  input  NB_DIV  divide value; a step occurs once every i_div+1 valid ticks.
- i_mode  input  2  motion mode: 00 rotate left, 01 rotate right, 10 bounce, 11 fill.
- i_load  input  1  synchronous load strobe.
- i_pattern  input  NB_LEDS  value loaded when i_load=1.
- o_led  output  NB_LEDS  current LED pattern (registered).
- o_dir  output  1  current direction: 1 = up (toward MSB), 0 = down.
- o_wrap  output  1  one-cycle event pulse (registered).

## Operation
- **Reset (async, i_rst_n=0):**
  - o_led = {NB_LEDS-1 zeros, 1}.
  - Prescaler count = 0.
  - o_dir = 1, o_wrap = 0.
  - All are held while i_rst_n=0.
- **Priority per clock edge:** reset > i_load > step > hold.
- **Load (i_load=1):**
  - o_led ← i_pattern; count ← 0; o_dir ← 1; o_wrap ← 0.
  - i_valid is ignored in that cycle.
  - A pattern of all zeros is legal. Rotate and bounce then keep it at zero, with no o_wrap.
- **Prescaler:**
  - On i_valid=1 with count == i_div: a step occurs and count ← 0.
  - On i_valid=1 with count < i_div: count ← count+1.
  - On i_valid=0: count holds.
  - i_div=0 steps on every valid tick.
  - If i_div is lowered below the current count, the count still runs up to NB_DIV-bit wrap before matching. Software must load or reset when it changes i_div.
- **Step, by mode (evaluated with the i_mode sampled on the step cycle):**
  - **00 rotate left:**
    - o_led ← {o_led[NB_LEDS-2:0], o_led[NB_LEDS-1]}; o_dir ← 1.
    - o_wrap ← o_led[NB_LEDS-1].
  - **01 rotate right:**
    - o_led ← {o_led[0], o_led[NB_LEDS-1:1]}; o_dir ← 0.
    - o_wrap ← o_led[0].
  - **10 bounce:** zero-fill shift, bits shifted out are lost.
    - o_dir=1 and o_led[MSB]=1: reverse (o_dir ← 0, o_led ← o_led>>1, o_wrap ← 1).
    - o_dir=1 otherwise: o_led ← o_led<<1.
    - o_dir=0 and o_led[0]=1: reverse (o_dir ← 1, o_led ← o_led<<1, o_wrap ← 1).
    - o_dir=0 otherwise: o_led ← o_led>>1.
    - The current o_dir is retained when entering this mode.
  - **11 fill:**
    - o_led all ones: o_led ← {zeros, 1} and o_wrap ← 1.
    - Otherwise: o_led ← {o_led[NB_LEDS-2:0], 1}.
    - o_dir ← 1.
- o_wrap is 0 on every cycle that is not a step producing a wrap.
- A mode change takes effect only at the next step. Neither the count nor o_led is disturbed by the change.

## Timing
- All outputs are registered; there is no combinational input→output path.
- o_led, o_dir and o_wrap update on the edge that samples the qualifying i_valid, i.e. one cycle of latency from the input.
- o_wrap is high for exactly one clock, aligned with the o_led value produced by the wrapping step.
- Reset assertion takes effect immediately, mid-step or mid-count. Deassertion is synchronised externally, and the first step can occur on the first edge after release.
- Back-to-back steps (i_div=0, i_valid=1 continuously) run at one pattern change per clock.

## Test plan
- **Reset and rotate left:** NB_LEDS=4. Reset → o_led=0001, o_dir=1, o_wrap=0. Release, i_div=0, mode 00, i_valid=1 → 0010, 0100, 1000, 0001, with o_wrap=1 only with 0001.
- **Prescaler:** i_div=2, i_valid pulsed every other cycle, mode 00. o_led changes once per 3 valid pulses (every 6 clocks), and idle cycles do not count.
- **Rotate right, then bounce:**
  - Mode 01 from 0001 → 1000 with o_wrap=1, then 0100.
  - Switch to mode 10 at 0010 with o_dir=0 → 0001, then 0010 with o_wrap=1 and o_dir=1, then 0100, 1000, then 0100 with o_wrap=1 and o_dir=0.
- **Fill:** mode 11 from 0001 → 0011, 0111, 1111, then 0001 with o_wrap=1.
- **Load:**
  - Mid-count (count=1, i_div=3): i_load=1, i_pattern=0101, i_valid=1 → o_led=0101 and count=0. The next step occurs after 4 more valid ticks; mode 00 then gives 1010.
  - Loading 0000 in mode 00 stays 0000 with o_wrap never asserted.
- **Async reset mid-operation:** with o_led=1000, count=2, o_dir=0, drop i_rst_n between clock edges. Outputs immediately show 0001, o_dir=1, o_wrap=0. After release, a full i_div+1 valid ticks are needed before the next step.
